// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and helpers for the PS/2 host transmit path.
//   ps2_state_t    - transmit sequencer states
//   PS2_FRAME_BITS - bits in one host-to-device frame (start, 8 data, parity, stop)
//   odd_parity()   - parity bit that makes the 9-bit {parity, data} count odd
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        ACK,
        WAIT_IDLE,
        DONE,
        ERROR
    } ps2_state_t;

    localparam int unsigned PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer plus falling-edge detect for one PS/2 line.
//   clk, rst  - system clock, asynchronous active-high reset
//   line_in   - raw pin readback (asynchronous)
//   line_sync - synchronized line level
//   fall      - high for one cycle after line_sync goes 1 -> 0
// Registers reset to 1 (idle bus level) so reset release never fakes an edge.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            prev      <= 1'b1;
        end else begin
            meta      <= line_in;
            line_sync <= meta;
            prev      <= line_sync;
        end
    end

    assign fall = prev & ~line_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmit sequencer (request-to-send,
// 8 data bits LSB first, odd parity, stop, ACK check).
//   clk, rst                      - system clock, asynchronous active-high reset
//   tx_valid, tx_data, tx_ready   - byte handshake, accepted only in IDLE
//   busy                          - high outside IDLE; receive path ignores the bus
//   tx_done, tx_err               - one-cycle result pulses (ACK / NACK or timeout)
//   ps2_clk_in, ps2_data_in       - raw pin readback
//   ps2_clk_hiz/drv, ps2_data_hiz/drv - open-drain gate controls (1 = release)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned REQ_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_hiz,
    output logic       ps2_clk_drv,
    output logic       ps2_data_hiz,
    output logic       ps2_data_drv
);

    // The start bit is the REQ phase, so the shift register holds data, parity, stop.
    localparam int unsigned     SHREG_W   = PS2_FRAME_BITS - 1;
    localparam logic [3:0]      STOP_IDX  = 4'(SHREG_W - 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);

    ps2_state_t         state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n, cnt_inc;
    logic [3:0]         bitcnt_q, bitcnt_n;
    logic [SHREG_W-1:0] shreg_q, shreg_n;
    logic               drv_bit;
    logic               timed_out;

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync),
        .fall      (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_data_in),
        .line_sync (data_sync),
        .fall      (data_fall_unused)
    );

    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign timed_out   = (cnt_q >= TMO_LIM);
    assign ps2_clk_drv = 1'b0;

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_inc;
        bitcnt_n = bitcnt_q;
        shreg_n  = shreg_q;
        drv_bit  = ps2_data_drv;
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (tx_valid) begin
                    shreg_n  = {1'b1, odd_parity(tx_data), tx_data};
                    bitcnt_n = '0;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q >= INH_LAST) begin
                    cnt_n   = '0;
                    state_n = REQ;
                end
            end
            REQ: begin
                // Counter enters BITS at 1: the entry cycle is the first timeout cycle,
                // so the error pulse lands exactly TIMEOUT_CYCLES after clock release.
                if (cnt_q >= REQ_LAST) begin
                    cnt_n   = CNT_W'(1);
                    state_n = BITS;
                end
            end
            BITS: begin
                if (timed_out) begin
                    state_n = ERROR;
                end else if (clk_fall) begin
                    if (bitcnt_q == STOP_IDX) begin
                        state_n = ACK;
                    end else begin
                        drv_bit  = shreg_q[0];
                        shreg_n  = shreg_q >> 1;
                        bitcnt_n = bitcnt_q + 4'd1;
                    end
                end
            end
            ACK: begin
                if (timed_out) begin
                    state_n = ERROR;
                end else if (clk_fall) begin
                    state_n = data_sync ? ERROR : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (timed_out) begin
                    state_n = ERROR;
                end else if (clk_sync && data_sync) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            ERROR:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            bitcnt_q <= bitcnt_n;
            shreg_q  <= shreg_n;
        end
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ready     <= 1'b1;
            busy         <= 1'b0;
            tx_done      <= 1'b0;
            tx_err       <= 1'b0;
            ps2_clk_hiz  <= 1'b1;
            ps2_data_hiz <= 1'b1;
            ps2_data_drv <= 1'b0;
        end else begin
            tx_ready     <= (state_n == IDLE);
            busy         <= (state_n != IDLE);
            tx_done      <= (state_n == DONE);
            tx_err       <= (state_n == ERROR);
            ps2_clk_hiz  <= !(state_n == INHIBIT || state_n == REQ);
            ps2_data_hiz <= !(state_n == REQ || state_n == BITS);
            ps2_data_drv <= (state_n == BITS) ? drv_bit : 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain bus and a
// simple PS/2 device model (clock half period HP system cycles).
module tb_ps2_host_tx;

    localparam int INH = 5000;
    localparam int REQ = 50;
    localparam int TMO = 2000;
    localparam int HP  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, busy, tx_done, tx_err;
    logic       clk_hiz, clk_drv, data_hiz, data_drv;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;

    int checks    = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;

    assign clk_line  = (clk_hiz  ? 1'b1 : clk_drv)  & dev_clk;
    assign data_line = (data_hiz ? 1'b1 : data_drv) & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .tx_done      (tx_done),
        .tx_err       (tx_err),
        .ps2_clk_in   (clk_line),
        .ps2_data_in  (data_line),
        .ps2_clk_hiz  (clk_hiz),
        .ps2_clk_drv  (clk_drv),
        .ps2_data_hiz (data_hiz),
        .ps2_data_drv (data_drv)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1)  err_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed no finish, expected finish before 3ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Called at the first negedge of INHIBIT; returns at the first negedge of BITS.
    task automatic measure(output int inh, output int req);
        inh = 0;
        req = 0;
        while (!clk_hiz && data_hiz && inh < INH + 10) begin inh++; tick(1); end
        while (!clk_hiz && !data_hiz && req < REQ + 10) begin req++; tick(1); end
    endtask

    // Device clocks 10 bits (sampling each in the high phase), then the ACK bit.
    task automatic dev_frame(input logic ack, input logic glitch, output logic [10:0] bits);
        tick(HP);
        bits[0] = data_line;
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            tick(HP);
            dev_clk = 1'b1;
            tick(HP / 2);
            bits[i] = data_line;
            if (glitch && i == 4) begin
                #1 dev_clk = 1'b0;
                #2 dev_clk = 1'b1;
            end
            tick(HP / 2);
        end
        dev_data = ack ? 1'b0 : 1'b1;
        tick(HP / 2);
        dev_clk = 1'b0;
        tick(HP);
        dev_clk = 1'b1;
        tick(HP / 2);
        dev_data = 1'b1;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (tx_done !== 1'b1 && k < 100) begin tick(1); k++; end
    endtask

    initial begin
        int          inh, req, k, d0, e0;
        logic [10:0] bits;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick(3);
        check("rst_clk_hiz",  clk_hiz,  1'b1);
        check("rst_data_hiz", data_hiz, 1'b1);
        check("rst_clk_drv",  clk_drv,  1'b0);
        check("rst_data_drv", data_drv, 1'b0);
        check("rst_ready",    tx_ready, 1'b1);
        check("rst_busy",     busy,     1'b0);
        check("rst_done_err", {tx_done, tx_err}, 2'b00);
        rst = 1'b0;
        tick(2);

        // 0xF4 with ACK
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4);
        check("f4_busy", busy, 1'b1);
        measure(inh, req);
        check("f4_inhibit_len", inh, INH);
        check("f4_req_len", req, REQ);
        dev_frame(1'b1, 1'b0, bits);
        check("f4_frame", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        wait_done(k);
        check("f4_done_seen", tx_done, 1'b1);
        tick(1);
        check("f4_done_one_cycle", tx_done, 1'b0);
        check("f4_busy_after", busy, 1'b0);
        tick(1);
        check("f4_done_count", done_cnt - d0, 1);
        check("f4_err_count", err_cnt - e0, 0);

        // 0x00, parity 1, device NACKs
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00);
        measure(inh, req);
        dev_frame(1'b0, 1'b0, bits);
        check("nack_frame", bits, {1'b1, 1'b1, 8'h00, 1'b0});
        tick(3);
        check("nack_err_count", err_cnt - e0, 1);
        check("nack_done_count", done_cnt - d0, 0);
        check("nack_hiz", {clk_hiz, data_hiz}, 2'b11);
        check("nack_busy", busy, 1'b0);

        // Device never clocks: timeout
        e0 = err_cnt;
        send(8'h55);
        measure(inh, req);
        k = 0;
        while (tx_err !== 1'b1 && k < TMO + 100) begin tick(1); k++; end
        check("tmo_latency", k, TMO);
        check("tmo_hiz", {clk_hiz, data_hiz}, 2'b11);
        tick(2);
        check("tmo_err_count", err_cnt - e0, 1);
        check("tmo_busy", busy, 1'b0);

        // tx_valid held high, data changes mid-frame
        d0 = done_cnt;
        tx_valid = 1'b1;
        tx_data  = 8'hF4;
        tick(1);
        measure(inh, req);
        tx_data = 8'hAA;
        dev_frame(1'b1, 1'b0, bits);
        check("hold_frame1", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        wait_done(k);
        check("hold_done_seen", tx_done, 1'b1);
        tick(1);
        check("hold_idle_ready", tx_ready, 1'b1);
        tick(1);
        check("hold_restart", {busy, clk_hiz}, 2'b10);
        tx_valid = 1'b0;
        measure(inh, req);
        check("hold_inhibit_len", inh, INH);
        dev_frame(1'b1, 1'b0, bits);
        check("hold_frame2", bits, {1'b1, 1'b1, 8'hAA, 1'b0});
        wait_done(k);
        tick(2);
        check("hold_done_count", done_cnt - d0, 2);

        // Reset during bit 4
        d0 = done_cnt; e0 = err_cnt;
        send(8'h5A);
        measure(inh, req);
        tick(HP);
        for (int i = 1; i <= 4; i++) begin
            dev_clk = 1'b0;
            tick(HP);
            dev_clk = 1'b1;
            tick(HP / 2);
        end
        check("mid_busy", {busy, data_hiz}, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("async_clk_hiz",  clk_hiz,  1'b1);
        check("async_data_hiz", data_hiz, 1'b1);
        check("async_data_drv", data_drv, 1'b0);
        check("async_ready_busy", {tx_ready, busy}, 2'b10);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        // Clean frame after reset, with a sub-cycle clock glitch
        d0 = done_cnt;
        send(8'hF4);
        measure(inh, req);
        check("clean_req_len", req, REQ);
        dev_frame(1'b1, 1'b1, bits);
        check("glitch_frame", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        wait_done(k);
        tick(2);
        check("glitch_done_count", done_cnt - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmit sequencer for the PS/2 mouse port. It sends command bytes such as 0xF4 (enable reporting) and 0xFF (reset).
- Drives the control inputs of the open-drain clock and data gates: the hi-Z enable and the drive value for each line.
- Executes the full PS/2 request-to-send protocol: clock inhibit, start request, 8 data bits, odd parity, stop bit and ACK check.
- Sits beside the PS/2 receive path. Receive logic must ignore the line while busy=1.

Parameters:
- INHIBIT_CYCLES, 5000: cycles the clock is held low before the request (100 us at 50 MHz).
- REQ_CYCLES, 50: cycles both lines are held low before the clock is released.
- TIMEOUT_CYCLES, 1000000: maximum cycles from clock release to ACK completion (20 ms at 50 MHz).
- CNT_W, 20: width of the shared cycle counter. Must satisfy 2^CNT_W > max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- tx_valid, in, 1: request to send tx_data.
- tx_data, in, 8: byte to send, LSB first.
- tx_ready, out, 1: high in IDLE. A byte is accepted when tx_valid && tx_ready.
- busy, out, 1: high in every state except IDLE.
- tx_done, out, 1: one-cycle pulse when the device ACKs successfully.
- tx_err, out, 1: one-cycle pulse on NACK or timeout.
- ps2_clk_in, in, 1: raw PS/2 clock pin readback (asynchronous).
- ps2_data_in, in, 1: raw PS/2 data pin readback (asynchronous).
- ps2_clk_hiz, out, 1: 1 releases the clock line.
- ps2_clk_drv, out, 1: value driven on the clock line when not hi-Z. Always 0.
- ps2_data_hiz, out, 1: 1 releases the data line.
- ps2_data_drv, out, 1: value driven on the data line when not hi-Z.

Behaviour:
- Reset values: ps2_clk_hiz=1, ps2_data_hiz=1, ps2_clk_drv=0, ps2_data_drv=0, tx_ready=1, busy=0, tx_done=0, tx_err=0. State=IDLE, counters cleared.
- Reset asserted mid-transfer releases both lines immediately (asynchronously). No done or err pulse is produced.
- Input conditioning: ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
  - fall = clk_sync_prev & ~clk_sync.
  - Edge detect latency is 3 cycles from the pin edge.
- IDLE:
  - On tx_valid, latch shreg = {1'b1 stop, ~^tx_data parity, tx_data}, set bitcnt=0, go to INHIBIT.
  - tx_valid is ignored in all other states; it is neither queued nor accepted.
- INHIBIT:
  - ps2_clk_hiz=0; data released.
  - Counts INHIBIT_CYCLES, then goes to REQ.
- REQ:
  - ps2_clk_hiz=0, ps2_data_hiz=0, ps2_data_drv=0 (start bit).
  - Counts REQ_CYCLES, then releases the clock and goes to BITS. The timeout counter starts here.
- BITS: the data line stays driven.
  - On each fall, ps2_data_drv=shreg[0], shreg shifts right and bitcnt increments.
  - Falls 1-8 present data bits 0-7; fall 9 presents parity.
  - At fall 10 (stop bit), set ps2_data_hiz=1 and go to ACK.
- ACK:
  - On the next fall, sample data_sync. 0 means ACK, go to WAIT_IDLE; 1 means NACK, go to ERROR.
- WAIT_IDLE:
  - Wait until clk_sync=1 and data_sync=1, then go to DONE.
- DONE: tx_done=1 for one cycle, then go to IDLE.
- ERROR:
  - Release both lines, tx_err=1 for one cycle, then go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in BITS, ACK or WAIT_IDLE, go to ERROR. Timeout takes priority over a fall arriving in the same cycle.
- Parity is odd over 8 data bits. Example: 0xF4 has 5 ones, so parity=0.
- Counters saturate; they never wrap.
- All outputs are registered. ps2_clk_drv is constant 0.

Decomposition:
- Package ps2_pkg holds:
  - state enum {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE, DONE, ERROR};
  - localparam PS2_FRAME_BITS=11;
  - the odd-parity function.
- Sub-module ps2_line_sync holds the 2-FF synchronizer plus falling-edge detect for one line. It is instantiated twice (clock and data); only the clock instance's fall output is used.

Test Plan:
- tx_data=0xF4; device model clocks at 12.5 kHz and ACKs.
  - Clock held low for exactly 5000 cycles, then data low for 50 cycles.
  - Frame bits on the line: 0,0,0,1,0,1,1,1,1,0,1 (start, LSB-first data, parity 0, stop 1).
  - One-cycle tx_done; busy low afterwards.
- tx_data=0x00, which gives parity=1.
  - Parity bit on the line is 1.
  - Device NACKs (data high at the 11th fall): tx_err pulses, tx_done stays 0, both hiz outputs return to 1.
- Device never clocks after release.
  - tx_err pulses exactly TIMEOUT_CYCLES cycles after entering BITS.
  - Both lines are released.
- tx_valid held high through the whole transfer with tx_data changing mid-frame.
  - Only the first byte is sent.
  - A second transfer starts one cycle after IDLE is re-entered.
- rst asserted during bit 4 of a frame.
  - Outputs take reset values asynchronously (before the next clk edge).
  - No tx_done or tx_err pulse.
  - The next tx_valid starts a clean frame.
- Device clock glitch shorter than 2 cycles.
  - No extra shift occurs; the frame content stays correct.
